sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving log2 of memory depth in 32-bit words (4096 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1C00_0000, giving the byte address of word 0.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, memory is zero-filled after reset.
REQ-004 SHALL provide clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide en  input  1  access request from the CPU, valid this cycle.
REQ-007 SHALL provide we  input  4  byte write enables, bit i for wdata[8i+7:8i]; all zero means read.
REQ-008 SHALL provide addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL provide wdata  input  32  write data.
REQ-010 SHALL provide rdata  output  32  read data, registered.
REQ-011 SHALL provide init_done  output  1  high once memory is usable.
REQ-012 SHALL provide err  output  1  sticky flag: out-of-range access or access during clear.
REQ-013 SHALL provide rd_cnt  output  32  count of accepted reads.
REQ-014 SHALL provide wr_cnt  output  32  count of accepted writes.

Function
REQ-015 SHALL decode word index idx = (addr - BASE_ADDR) >> 2; the access is in range iff addr >= BASE_ADDR and idx < 2^ADDR_W.
REQ-016 SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 SHALL enter CLEAR on reset when CLEAR_ON_RESET=1, otherwise READY.
REQ-018 SHALL, in CLEAR, write zero to one word per cycle, starting at index 0 and ending at 2^ADDR_W-1, then move to READY on the next cycle; CLEAR lasts exactly 2^ADDR_W cycles.
REQ-019 SHALL drive init_done=1 only in READY.
REQ-020 SHALL, in READY, with en=1, we=0 and in range, load rdata with mem[idx] at the next rising edge (1-cycle read latency) and increment rd_cnt.
REQ-021 SHALL, in READY, with en=1, we!=0 and in range, update only the enabled bytes of mem[idx] at the edge, leave rdata unchanged, and increment wr_cnt by 1 whatever the number of enabled bytes.
REQ-022 SHALL hold rdata unchanged on any cycle with en=0.
REQ-023 SHALL, for an out-of-range read, load rdata with 32'h0, set err, and leave rd_cnt unchanged.
REQ-024 SHALL, for an out-of-range write, leave memory unchanged, set err, and leave wr_cnt unchanged.
REQ-025 SHALL, in CLEAR with en=1, ignore the access (no memory change, rdata unchanged, counters unchanged) and set err.
REQ-026 SHALL keep err set until reset.
REQ-027 SHALL let rd_cnt and wr_cnt wrap modulo 2^32.
REQ-028 SHALL return the newly written value on a read issued in the cycle after a write to the same word, with no stall.

Reset
REQ-029 SHALL, on reset, force rdata=0, err=0, rd_cnt=0, wr_cnt=0 and clear index=0.
REQ-030 SHALL drive init_done=0 during reset when CLEAR_ON_RESET=1.
REQ-031 SHALL, when reset is asserted mid-CLEAR, restart the clear at index 0.
REQ-032 SHALL, when reset is asserted in READY, retain memory contents if CLEAR_ON_RESET=0.

Verification
REQ-033 SHALL verify clear timing: ADDR_W=4, deassert reset -> init_done rises 16 cycles later, and reading every word returns 0.
REQ-034 SHALL verify byte-enable writes: write 32'hAABBCCDD with we=4'b1111, then 32'h11223344 with we=4'b0101 to BASE_ADDR+8, then read -> rdata=32'hAA22CC44 one cycle after the read, wr_cnt=2, rd_cnt=1.
REQ-035 SHALL verify read-after-write: write 32'h12345678 to BASE_ADDR+4, read it on the next cycle -> rdata=32'h12345678 on the following cycle.
REQ-036 SHALL verify range checking: read BASE_ADDR+(4<<ADDR_W), then write BASE_ADDR-4 -> rdata=0, err=1, counters unchanged, memory unchanged.
REQ-037 SHALL verify access during clear: en=1 while init_done=0 -> err=1, rd_cnt=0.
REQ-038 SHALL verify reset mid-clear: pulse reset at clear index 7 -> init_done rises 2^ADDR_W cycles after reset release.

Source files
------------

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Word-addressed 32-bit on-chip SRAM responding to a simple CPU access port.
// After reset the memory can optionally be zero-filled, one word per cycle,
// before accesses are accepted. Reads have one cycle of latency; writes honour
// per-byte enables. Out-of-range accesses, and any access made while the clear
// is still running, are dropped and raise a sticky error flag.
//
// Parameters
//   ADDR_W         log2 of memory depth in 32-bit words
//   BASE_ADDR      byte address of word 0
//   CLEAR_ON_RESET 1: zero-fill memory after reset; 0: memory usable at once
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   reset      synchronous, active-high reset
//   en         access request, valid this cycle
//   we[3:0]    byte write enables (bit i -> wdata[8i+7:8i]); all zero = read
//   addr[31:0] byte address, bits [1:0] ignored
//   wdata      write data
//   rdata      registered read data
//   init_done  high once the memory accepts accesses
//   err        sticky: out-of-range access or access during clear
//   rd_cnt     number of accepted reads (wraps)
//   wr_cnt     number of accepted writes (wraps)
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        init_done,
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_idx_reg;
    logic              init_done_reg;
    logic              err_reg;
    logic [31:0]       rd_cnt_reg;
    logic [31:0]       wr_cnt_reg;

    // ---------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below BASE_ADDR,
    // so the explicit lower-bound compare is what rejects those.
    // ---------------------------------------------------------------------
    logic [31:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] idx;

    assign offset   = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && ((offset >> (ADDR_W + 2)) == 32'd0);
    assign idx      = offset[ADDR_W+1:2];

    // ---------------------------------------------------------------------
    // Access qualification
    // ---------------------------------------------------------------------
    logic clearing;
    logic ready;
    logic is_read;
    logic rd_acc;
    logic wr_acc;
    logic rd_oor;
    logic bad_acc;

    assign clearing = (state_reg == ST_CLEAR);
    assign ready    = (state_reg == ST_READY);
    assign is_read  = (we == 4'b0000);
    assign rd_acc   = ready && en && is_read && in_range;
    assign wr_acc   = ready && en && !is_read && in_range;
    assign rd_oor   = ready && en && is_read && !in_range;
    assign bad_acc  = en && (clearing || !in_range);

    // Single shared write port: the clear sequencer owns it while clearing,
    // the CPU otherwise. Writes are suppressed while reset is asserted so a
    // reset never disturbs retained contents.
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    assign mem_wr    = !reset && (clearing || wr_acc);
    assign mem_idx   = clearing ? clr_idx_reg : idx;
    assign mem_be    = clearing ? 4'hF : we;
    assign mem_wdata = clearing ? 32'd0 : wdata;

    // ---------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane keeps each lane a plain
    // single-write-port array with its own registered read.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (mem_wr && mem_be[gi]) begin
                    mem[mem_idx] <= mem_wdata[8*gi +: 8];
                end
            end

            // Holds on writes and idle cycles; out-of-range reads return zero.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_byte_reg <= 8'd0;
                end else if (rd_acc) begin
                    rd_byte_reg <= mem[idx];
                end else if (rd_oor) begin
                    rd_byte_reg <= 8'd0;
                end
            end

            assign rdata[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Control FSM, error flag and counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            init_done_reg <= !CLEAR_ON_RESET;
            clr_idx_reg   <= '0;
            err_reg       <= 1'b0;
            rd_cnt_reg    <= 32'd0;
            wr_cnt_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    // Last word is being zeroed this cycle.
                    if (&clr_idx_reg) begin
                        state_reg     <= ST_READY;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_READY;
                    init_done_reg <= 1'b1;
                end
            endcase

            if (bad_acc) begin
                err_reg <= 1'b1;
            end
            if (rd_acc) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if (wr_acc) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
        end
    end

    assign init_done = init_done_reg;
    assign err       = err_reg;
    assign rd_cnt    = rd_cnt_reg;
    assign wr_cnt    = wr_cnt_reg;

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//
// Directed bench for sram_responder with a 16-word memory. u_dut zero-fills
// after reset; u_ret has clearing disabled and is used to check that memory
// contents survive a reset.
// -----------------------------------------------------------------------------
module tb_sram_responder;

    localparam int          ADDR_W = 4;
    localparam logic [31:0] BASE   = 32'h1C00_0000;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    logic        reset1;
    logic        en1;
    logic [3:0]  we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        init_done1;
    logic        err1;
    logic [31:0] rd_cnt1;
    logic [31:0] wr_cnt1;

    int errors = 0;
    int checks = 0;
    int n;

    sram_responder #(
        .ADDR_W         (ADDR_W),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .init_done (init_done),
        .err       (err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    sram_responder #(
        .ADDR_W         (ADDR_W),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b0)
    ) u_ret (
        .clk       (clk),
        .reset     (reset1),
        .en        (en1),
        .we        (we1),
        .addr      (addr1),
        .wdata     (wdata1),
        .rdata     (rdata1),
        .init_done (init_done1),
        .err       (err1),
        .rd_cnt    (rd_cnt1),
        .wr_cnt    (wr_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        $display("access we=%b addr=%h wdata=%h -> rdata=%h err=%b rd_cnt=%0d wr_cnt=%0d",
                 w, a, d, rdata, err, rd_cnt, wr_cnt);
        en = 1'b0;
        we = 4'b0000;
    endtask

    // Counts cycles until init_done rises, bounded.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        we     = 4'b0000;
        addr   = 32'd0;
        wdata  = 32'd0;
        reset1 = 1'b1;
        en1    = 1'b0;
        we1    = 4'b0000;
        addr1  = 32'd0;
        wdata1 = 32'd0;

        // ---------------- reset state
        tick();
        tick();
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd_cnt", rd_cnt, 32'd0);
        check("rst_wr_cnt", wr_cnt, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("ret_rst_init_done", {31'd0, init_done1}, 32'd1);

        // ---------------- clear timing
        reset = 1'b0;
        wait_init(n);
        $display("clear finished after %0d cycles", n);
        check("clear_cycles", n, 32'd16);

        // ---------------- every word reads zero after clear
        for (int i = 0; i < 16; i++) begin
            access(4'b0000, BASE + 32'(4 * i), 32'd0);
            check($sformatf("zero_word%0d", i), rdata, 32'd0);
        end
        check("zero_rd_cnt", rd_cnt, 32'd16);
        check("zero_err", {31'd0, err}, 32'd0);

        // ---------------- byte-enable writes
        rdata_seed: begin
            access(4'b0000, BASE + 32'd20, 32'd0);       // rdata <= 0, rd_cnt 17
        end
        access(4'b1111, BASE + 32'd8, 32'hAABB_CCDD);
        check("be_wr_holds_rdata", rdata, 32'd0);
        access(4'b0101, BASE + 32'd8, 32'h1122_3344);
        access(4'b0000, BASE + 32'd8, 32'd0);
        check("be_rdata", rdata, 32'hAA22_CC44);
        check("be_wr_cnt", wr_cnt, 32'd2);
        check("be_rd_cnt", rd_cnt, 32'd18);
        access(4'b0000, BASE + 32'd11, 32'd0);        // low address bits ignored
        check("be_low_bits", rdata, 32'hAA22_CC44);

        // ---------------- read after write
        access(4'b1111, BASE + 32'd4, 32'h1234_5678);
        access(4'b0000, BASE + 32'd4, 32'd0);
        check("raw_rdata", rdata, 32'h1234_5678);
        tick();
        check("idle_holds_rdata", rdata, 32'h1234_5678);
        check("raw_wr_cnt", wr_cnt, 32'd3);
        check("raw_rd_cnt", rd_cnt, 32'd20);

        // ---------------- range checking
        access(4'b0000, BASE + 32'd64, 32'd0);
        check("oor_rd_rdata", rdata, 32'd0);
        check("oor_rd_err", {31'd0, err}, 32'd1);
        check("oor_rd_cnt", rd_cnt, 32'd20);
        access(4'b1111, BASE - 32'd4, 32'hDEAD_BEEF);
        access(4'b1111, BASE + 32'd76, 32'hFEED_FACE);
        check("oor_wr_cnt", wr_cnt, 32'd3);
        access(4'b0000, BASE + 32'd60, 32'd0);
        check("oor_mem_word15", rdata, 32'd0);
        access(4'b0000, BASE + 32'd12, 32'd0);
        check("oor_mem_word3", rdata, 32'd0);
        check("oor_err_sticky", {31'd0, err}, 32'd1);

        // ---------------- access during clear
        reset = 1'b1;
        tick();
        check("rst2_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick();
        access(4'b0000, BASE + 32'd8, 32'd0);
        check("clr_acc_err", {31'd0, err}, 32'd1);
        check("clr_acc_rd_cnt", rd_cnt, 32'd0);
        check("clr_acc_rdata", rdata, 32'd0);
        access(4'b1111, BASE + 32'd8, 32'h5555_AAAA);
        check("clr_acc_wr_cnt", wr_cnt, 32'd0);
        wait_init(n);
        access(4'b0000, BASE + 32'd8, 32'd0);
        check("clr_word2_zero", rdata, 32'd0);

        // ---------------- reset mid-clear at index 7
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_init(n);
        $display("clear after mid-clear reset finished after %0d cycles", n);
        check("midclr_cycles", n, 32'd16);

        // ---------------- retention without clear
        reset1 = 1'b0;
        tick();
        en1    = 1'b1;
        we1    = 4'b1111;
        addr1  = BASE + 32'd8;
        wdata1 = 32'hCAFE_F00D;
        tick();
        en1    = 1'b0;
        we1    = 4'b0000;
        reset1 = 1'b1;
        tick();
        check("ret_rst_wr_cnt", wr_cnt1, 32'd0);
        reset1 = 1'b0;
        en1    = 1'b1;
        tick();
        en1    = 1'b0;
        $display("retention read addr=%h -> rdata=%h", addr1, rdata1);
        check("ret_rdata", rdata1, 32'hCAFE_F00D);
        check("ret_rd_cnt", rd_cnt1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
